// File: rtl/sr_flag_arbiter_pkg.sv
// Shared types and constants for the SR flag arbiter.
// Latency: n/a (package). Backpressure: n/a.
// Holds the FSM encoding, op encoding and the round-robin pointer wrap helper.
package sr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic OP_SET  = 1'b1;
    localparam logic OP_CLR  = 1'b0;
    localparam int   MAX_REQ = 8;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bundle for the SR flag arbiter: requests in, ack/pulses/status out.
// Latency: n/a (wiring only). Backpressure: req_vld is held until req_ack.
// master = requester side, slave = arbiter side.
interface sr_flag_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_vld;
    logic [NUM_REQ-1:0]         req_op;
    logic [NUM_REQ-1:0]         lock_req;
    logic [NUM_REQ-1:0]         req_ack;
    logic                       s;
    logic                       r;
    logic [$clog2(NUM_REQ)-1:0] owner;
    logic                       locked;

    modport master (
        output req_vld, req_op, lock_req,
        input  req_ack, s, r, owner, locked
    );

    modport slave (
        input  req_vld, req_op, lock_req,
        output req_ack, s, r, owner, locked
    );
endinterface

// File: rtl/sr_flag_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted vld bit at or after ptr.
// Latency: 0 cycles (pure combinational). Backpressure: none; found=0 when vld is empty.
// Searches from ptr upward with wrap, so the lowest offset from ptr wins.
module rr_pick
    import sr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         vld,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [$clog2(NUM_REQ)-1:0] win,
    output logic                       found
);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0] idx;

    // Walk offsets from highest to lowest so the closest hit to ptr is the one left standing.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NUM_REQ);
            if (vld[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing one SR flop: one-cycle s/r pulse + one-hot ack per grant (SR_ARB_LOCK_EN adds owner lock).
// Latency: request sampled at edge t, ack and s/r high in cycle t+1; all outputs registered.
// Backpressure: requests held until acked; one op per 2 cycles, other requesters stall while locked.
module sr_flag_arbiter
    import sr_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input logic              clk,
    input logic              rst,
    sr_flag_arbiter_if.slave arb
);
    localparam int                 IW  = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t             state;
    logic [IW-1:0]      rr_ptr;
    logic [IW-1:0]      owner_q;
    logic [IW-1:0]      win;
    logic [IW-1:0]      gnt_idx;
    logic               found;
    logic               gnt_go;
    logic               op;
    logic [NUM_REQ-1:0] ack_q;
    logic               s_q;
    logic               r_q;
    logic               locked_q;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .vld   (arb.req_vld),
        .ptr   (rr_ptr),
        .win   (win),
        .found (found)
    );

    // Grants only start from IDLE or LOCKED, so ISSUE always has a free cycle after it.
    always_comb begin
        gnt_go  = 1'b0;
        gnt_idx = win;
        case (state)
            ST_IDLE: gnt_go = found;
`ifdef SR_ARB_LOCK_EN
            ST_LOCKED: begin
                gnt_idx = owner_q;
                gnt_go  = arb.lock_req[owner_q] & arb.req_vld[owner_q];
            end
`endif
            default: gnt_go = 1'b0;
        endcase
    end

    assign op = arb.req_op[gnt_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner_q  <= '0;
            ack_q    <= '0;
            s_q      <= 1'b0;
            r_q      <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            ack_q <= '0;
            s_q   <= 1'b0;
            r_q   <= 1'b0;
            if (gnt_go) begin
                owner_q <= gnt_idx;
                ack_q   <= ONE << gnt_idx;
                s_q     <= op;
                r_q     <= ~op;
                state   <= ST_ISSUE;
            end else if (state == ST_ISSUE) begin
                rr_ptr <= IW'(wrap_inc(int'(owner_q), NUM_REQ));
`ifdef SR_ARB_LOCK_EN
                locked_q <= arb.lock_req[owner_q];
                state    <= arb.lock_req[owner_q] ? ST_LOCKED : ST_IDLE;
`else
                state    <= ST_IDLE;
`endif
            end
`ifdef SR_ARB_LOCK_EN
            else if (state == ST_LOCKED && !arb.lock_req[owner_q]) begin
                state    <= ST_IDLE;
                locked_q <= 1'b0;
            end
`endif
        end
    end

`ifndef SR_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^arb.lock_req;
`endif

    assign arb.req_ack = ack_q;
    assign arb.s       = s_q;
    assign arb.r       = r_q;
    assign arb.owner   = owner_q;
    assign arb.locked  = locked_q;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Directed bench for sr_flag_arbiter with a behavioural SR flop standing in for the parent's sr_flipFlop.
module tb_sr_flag_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic q;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sr_flag_arbiter_if #(.NUM_REQ(4)) arb();

    sr_flag_arbiter #(.NUM_REQ(4)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    always @(posedge clk) begin
        if (rst)        q <= 1'b0;
        else if (arb.s) q <= 1'b1;
        else if (arb.r) q <= 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        arb.req_vld = '0; arb.req_op = '0; arb.lock_req = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        arb.req_vld = 4'hF; arb.req_op = 4'hF; arb.lock_req = 4'hF;
        tick(); tick(); tick();
        tests++; if (arb.req_ack !== 4'b0000) begin fails++; $display("FAIL reset_ack: got %b want 0000", arb.req_ack); end
        tests++; if (arb.s !== 1'b0) begin fails++; $display("FAIL reset_s: got %b want 0", arb.s); end
        tests++; if (arb.r !== 1'b0) begin fails++; $display("FAIL reset_r: got %b want 0", arb.r); end
        tests++; if (arb.owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", arb.owner); end
        tests++; if (arb.locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", arb.locked); end
        arb.req_vld = '0; arb.req_op = '0; arb.lock_req = '0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_set();
        do_reset();
        arb.req_op = 4'b0100; arb.req_vld = 4'b0100;
        tick();
        tests++; if (arb.req_ack !== 4'b0100) begin fails++; $display("FAIL single_ack: got %b want 0100", arb.req_ack); end
        tests++; if (arb.s !== 1'b1 || arb.r !== 1'b0) begin fails++; $display("FAIL single_sr: got s=%b r=%b want s=1 r=0", arb.s, arb.r); end
        tests++; if (arb.owner !== 2'd2) begin fails++; $display("FAIL single_owner: got %0d want 2", arb.owner); end
        arb.req_vld = '0;
        tick();
        tests++; if (q !== 1'b1) begin fails++; $display("FAIL single_q: got %b want 1", q); end
        tests++; if (arb.req_ack !== 4'b0000 || arb.s !== 1'b0) begin fails++; $display("FAIL single_after: got ack=%b s=%b want 0000/0", arb.req_ack, arb.s); end
    endtask

    task automatic test_fairness();
        logic [3:0] exp;
        do_reset();
        arb.req_op = 4'b0101; arb.req_vld = 4'hF;
        for (int k = 0; k < 10; k++) begin
            tick();
            exp = (k % 2 == 0) ? (4'b0001 << ((k / 2) % 4)) : 4'b0000;
            tests++; if (arb.req_ack !== exp) begin fails++; $display("FAIL fair_ack[%0d]: got %b want %b", k, arb.req_ack, exp); end
            if (k % 2 == 0) begin
                tests++; if (arb.owner !== 2'((k / 2) % 4)) begin fails++; $display("FAIL fair_owner[%0d]: got %0d want %0d", k, arb.owner, (k / 2) % 4); end
            end
        end
        arb.req_vld = '0;
    endtask

    // Entered with rr_ptr=1 left over from the fairness run.
    task automatic test_reset_mid_issue();
        arb.req_op = 4'b0100; arb.req_vld = 4'b0100;
        tick();
        tests++; if (arb.req_ack !== 4'b0100) begin fails++; $display("FAIL rmi_pre_ack: got %b want 0100", arb.req_ack); end
        rst = 1'b1;
        tick();
        tests++; if (arb.req_ack !== 4'b0000 || arb.s !== 1'b0 || arb.r !== 1'b0) begin fails++; $display("FAIL rmi_outputs: got ack=%b s=%b r=%b want 0", arb.req_ack, arb.s, arb.r); end
        tests++; if (arb.owner !== 2'd0 || arb.locked !== 1'b0) begin fails++; $display("FAIL rmi_owner: got owner=%0d locked=%b want 0/0", arb.owner, arb.locked); end
        rst = 1'b0;
        arb.req_op = 4'b0101; arb.req_vld = 4'b0101;
        tick();
        tests++; if (arb.req_ack !== 4'b0001) begin fails++; $display("FAIL rmi_ptr_cleared: got %b want 0001", arb.req_ack); end
        arb.req_vld = 4'b0100;
        tick();
        tests++; if (arb.req_ack !== 4'b0000) begin fails++; $display("FAIL rmi_gap: got %b want 0000", arb.req_ack); end
        tick();
        tests++; if (arb.req_ack !== 4'b0100) begin fails++; $display("FAIL rmi_reserved: got %b want 0100", arb.req_ack); end
        arb.req_vld = '0;
        tick();
    endtask

    task automatic test_conflict();
        logic [4:0] es, er, eq;
        es = 5'b00001; er = 5'b00100; eq = 5'b00110;
        do_reset();
        arb.req_op = 4'b0001; arb.req_vld = 4'b0011;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests++; if ((arb.s & arb.r) !== 1'b0) begin fails++; $display("FAIL conf_sr_both[%0d]: got s=%b r=%b want not both", k, arb.s, arb.r); end
            tests++; if (arb.s !== es[k] || arb.r !== er[k]) begin fails++; $display("FAIL conf_pulse[%0d]: got s=%b r=%b want s=%b r=%b", k, arb.s, arb.r, es[k], er[k]); end
            tests++; if (q !== eq[k]) begin fails++; $display("FAIL conf_q[%0d]: got %b want %b", k, q, eq[k]); end
            arb.req_vld = arb.req_vld & ~arb.req_ack;
        end
    endtask

    task automatic test_lock();
        logic exp_lk;
`ifdef SR_ARB_LOCK_EN
        exp_lk = 1'b1;
`else
        exp_lk = 1'b0;
`endif
        do_reset();
        arb.req_op = 4'b0010; arb.req_vld = 4'b1010; arb.lock_req = 4'b0010;
        tick();
        tests++; if (arb.req_ack !== 4'b0010 || arb.locked !== 1'b0) begin fails++; $display("FAIL lock_first: got ack=%b locked=%b want 0010/0", arb.req_ack, arb.locked); end
        tick();
        tests++; if (arb.locked !== exp_lk) begin fails++; $display("FAIL lock_state: got %b want %b", arb.locked, exp_lk); end
`ifdef SR_ARB_LOCK_EN
        tick();
        tests++; if (arb.req_ack !== 4'b0010) begin fails++; $display("FAIL lock_op2: got %b want 0010", arb.req_ack); end
        tick(); tick();
        tests++; if (arb.req_ack !== 4'b0010) begin fails++; $display("FAIL lock_op3: got %b want 0010", arb.req_ack); end
        arb.lock_req = 4'b0000; arb.req_vld = 4'b1000;
        tick();
        tests++; if (arb.locked !== 1'b0 || arb.req_ack !== 4'b0000) begin fails++; $display("FAIL lock_release: got locked=%b ack=%b want 0/0000", arb.locked, arb.req_ack); end
        tick();
        tests++; if (arb.req_ack !== 4'b1000) begin fails++; $display("FAIL lock_r3_after: got %b want 1000", arb.req_ack); end
`else
        tick();
        tests++; if (arb.req_ack !== 4'b1000 || arb.locked !== 1'b0) begin fails++; $display("FAIL nolock_r3: got ack=%b locked=%b want 1000/0", arb.req_ack, arb.locked); end
`endif
        arb.req_vld = '0; arb.lock_req = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        arb.req_op = 4'b0001; arb.req_vld = 4'b0001;
        tick();
        tests++; if (arb.req_ack !== 4'b0001 || arb.s !== 1'b1) begin fails++; $display("FAIL b2b_first: got ack=%b s=%b want 0001/1", arb.req_ack, arb.s); end
        arb.req_op = 4'b0000;
        tick();
        tests++; if (arb.req_ack !== 4'b0000 || q !== 1'b1) begin fails++; $display("FAIL b2b_gap: got ack=%b q=%b want 0000/1", arb.req_ack, q); end
        tick();
        tests++; if (arb.req_ack !== 4'b0001 || arb.r !== 1'b1 || arb.s !== 1'b0) begin fails++; $display("FAIL b2b_second: got ack=%b s=%b r=%b want 0001/0/1", arb.req_ack, arb.s, arb.r); end
        arb.req_vld = '0;
        tick();
        tests++; if (q !== 1'b0 || arb.req_ack !== 4'b0000) begin fails++; $display("FAIL b2b_end: got q=%b ack=%b want 0/0000", q, arb.req_ack); end
    endtask

    initial begin
        arb.req_vld = '0; arb.req_op = '0; arb.lock_req = '0;
        test_reset();
        test_single_set();
        test_fairness();
        test_reset_mid_issue();
        test_conflict();
        test_lock();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
